memory_access_unit: RTL
=======================

Name: memory_access_unit

Overview:
- Memory-stage data-bus master of the pipelined MIPS core; sits between the Execute/Memory pipeline register and the Memory/Writeback register.
- Turns load/store control plus the ALU-computed address into word-aligned Avalon-style bus transactions with byte enables.
- Sign/zero-extends and merges load data into read_data_memory; stalls the pipeline while the bus is busy.

Parameters:
- READ_LATENCY, 1, fixed cycles from accepted read to valid data_readdata; legal values 1..4.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- memory_read_memory  input  1  load in memory stage
- memory_write_memory  input  1  store in memory stage
- load_store_type_memory  input  3  000 W, 001 B, 010 BU, 011 H, 100 HU, 101 LWL, 110 LWR
- ALU_output_memory  input  32  byte address
- write_data_memory  input  32  rt value: store data, and LWL/LWR merge source
- external_stall  input  1  downstream or hazard stall, other than this block
- data_address  output  32  {ALU_output_memory[31:2],2'b00}
- data_read  output  1  bus read request
- data_write  output  1  bus write request
- data_byteenable  output  4  lane k = bits 8k+7:8k, little-endian
- data_writedata  output  32  lane-aligned store data
- data_readdata  input  32  bus read data
- data_waitrequest  input  1  request not accepted this cycle
- read_data_memory  output  32  formatted load result, to MEM/WB
- memory_stall  output  1  freeze PC and all registers up to EX/MEM
- address_error  output  1  misaligned access flag (optional feature)

Behaviour:
- Reset: state IDLE, every output 0, latency counter 0, captured data register 0.
- States: IDLE, REQ, RDATA, DONE.
- IDLE, no request: outputs 0, memory_stall 0.
- IDLE, read or write request: data_read/data_write asserted combinationally.
  - Waitrequest high: go to REQ.
  - Read accepted: go to RDATA, counter = READ_LATENCY.
  - Write accepted: memory_stall 0. If external_stall is high, go to DONE so the write is never reissued.
- REQ: request and its signals held stable until waitrequest is low, then same exits as IDLE.
- memory_stall = 1 in REQ and RDATA, and in IDLE for any read or any unaccepted write.
- RDATA: counter decrements each cycle. At 1, data_readdata is sampled and formatted:
  - read_data_memory is driven combinationally and memory_stall is 0.
  - external_stall low: next IDLE.
  - external_stall high: capture into register, next DONE.
- DONE: no bus requests. read_data_memory comes from the captured register, memory_stall 0. Leave to IDLE the first cycle external_stall is low.
- Byte offset k = address[1:0].
- Stores:
  - SB: byteenable = 1<<k, byte replicated on all lanes.
  - SH: byteenable 0011 or 1100, halfword replicated.
  - SW: 1111.
- Loads: read byteenable is always 1111.
  - B/BU: lane k, sign- or zero-extended.
  - H/HU: lanes k+1:k, extended.
  - W: full word.
  - LWL: (word << 8*(3-k)) | (rt & low 8*(3-k) bits mask).
  - LWR: (word >> 8*k) | (rt & high 8*k bits mask).
- Simultaneous read and write request: read wins, write ignored (illegal control; flagged by assertion in simulation).
- Reset mid-transaction: abort immediately to IDLE. Requests drop in the reset cycle, and no late data is consumed.

Optional Feature:
- MEMORY_ALIGN_CHECK_EN defined:
  - W/SW with address[1:0]≠0, or H/HU/SH with address[0]≠0: no bus request.
  - address_error pulses 1 that cycle, read_data_memory = 0, memory_stall 0, state stays IDLE.
- Undefined: address_error tied 0, misaligned low bits ignored per the lane rules above. For H/HU/SH, address[0] is dropped.

Test Plan:
- LB at 0x1003, readdata 0x80FF_FF12, no wait -> byteenable 1111, stall 1 for 1 cycle, read_data 0xFFFF_FF80. LBU on the same data -> 0x0000_0080.
- SH at 0x2002, write_data 0x0000_BEEF, waitrequest high 3 cycles -> data_write held 4 cycles, byteenable 1100, writedata 0xBEEF_BEEF, stall 1 for 3 cycles.
- SW to 0x3000 with external_stall high 2 cycles -> exactly one cycle with data_write=1, state DONE then IDLE.
- LWL at 0x4001, rt 0x1122_3344, readdata 0xAABB_CCDD -> 0xCCDD_3344. LWR at 0x4001, same rt and readdata -> 0x11AA_BBCC.
- READ_LATENCY=3, LW at 0x5000 -> stall 1 for 3 cycles, result equals readdata. Reset asserted in the second latency cycle -> all outputs 0 next cycle.
- With MEMORY_ALIGN_CHECK_EN, LW at 0x6002 -> no data_read, address_error 1 for 1 cycle, read_data 0.

Source files
------------

// File: rtl/memory_access_unit.sv
// Memory-stage data-bus master: word-aligned Avalon-style requests, byte-lane stores, formatted loads, pipeline stall.
// Optional misaligned-access trap is compiled in when MEMORY_ALIGN_CHECK_EN is defined.
module memory_access_unit #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_read_memory,
  input  logic        memory_write_memory,
  input  logic [2:0]  load_store_type_memory,
  input  logic [31:0] ALU_output_memory,
  input  logic [31:0] write_data_memory,
  input  logic        external_stall,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [3:0]  data_byteenable,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata,
  input  logic        data_waitrequest,
  output logic [31:0] read_data_memory,
  output logic        memory_stall,
  output logic        address_error
);
  typedef enum logic [1:0] {IDLE, REQ, RDATA, DONE} state_t;
  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t      r_state;
  logic [2:0]  r_count;
  logic [31:0] r_capture;

  logic [1:0]  w_k;
  logic        w_misaligned, w_active, w_rd_req, w_wr_req, w_accept, w_data_cycle;
  logic [3:0]  w_store_be;
  logic [31:0] w_store_data, w_load_fmt;

  function automatic logic [31:0] format_load(input logic [31:0] word, input logic [31:0] rt,
                                              input logic [2:0] kind, input logic [1:0] k);
    logic [7:0]  b;
    logic [15:0] h;
    logic [4:0]  sl, sr;
    b  = word[{k, 3'b000} +: 8];
    h  = k[1] ? word[31:16] : word[15:0];
    sl = {~k, 3'b000};
    sr = {k, 3'b000};
    case (kind)
      3'b001:  format_load = {{24{b[7]}}, b};
      3'b010:  format_load = {24'd0, b};
      3'b011:  format_load = {{16{h[15]}}, h};
      3'b100:  format_load = {16'd0, h};
      3'b101:  format_load = (word << sl) | (rt & ~(32'hFFFF_FFFF << sl));
      3'b110:  format_load = (word >> sr) | (rt & ~(32'hFFFF_FFFF >> sr));
      default: format_load = word;
    endcase
  endfunction

  assign w_k = ALU_output_memory[1:0];

`ifdef MEMORY_ALIGN_CHECK_EN
  always_comb begin
    w_misaligned = 1'b0;
    case (load_store_type_memory)
      3'b000:         w_misaligned = (w_k != 2'b00);
      3'b011, 3'b100: w_misaligned = w_k[0];
      default:        w_misaligned = 1'b0;
    endcase
  end
`else
  assign w_misaligned = 1'b0;
`endif

  // Sub-word stores replicate the datum on every lane; byte enables pick the live lane(s).
  always_comb begin
    w_store_be   = 4'b1111;
    w_store_data = write_data_memory;
    case (load_store_type_memory)
      3'b001, 3'b010: begin
        w_store_be   = 4'b0001 << w_k;
        w_store_data = {4{write_data_memory[7:0]}};
      end
      3'b011, 3'b100: begin
        w_store_be   = w_k[1] ? 4'b1100 : 4'b0011;
        w_store_data = {2{write_data_memory[15:0]}};
      end
      default: ;
    endcase
  end

  // Requests are gated by reset so the bus sees nothing in the reset cycle itself.
  assign w_active     = (r_state == IDLE) || (r_state == REQ);
  assign w_rd_req     = w_active && memory_read_memory && !w_misaligned && !reset;
  assign w_wr_req     = w_active && memory_write_memory && !memory_read_memory && !w_misaligned && !reset;
  assign w_accept     = !data_waitrequest;
  assign w_data_cycle = (r_state == RDATA) && (r_count == 3'd1);
  assign w_load_fmt   = format_load(data_readdata, write_data_memory, load_store_type_memory, w_k);

  assign data_address     = (w_rd_req || w_wr_req) ? {ALU_output_memory[31:2], 2'b00} : 32'd0;
  assign data_read        = w_rd_req;
  assign data_write       = w_wr_req;
  assign data_byteenable  = w_rd_req ? 4'b1111 : (w_wr_req ? w_store_be : 4'b0000);
  assign data_writedata   = w_wr_req ? w_store_data : 32'd0;
  assign read_data_memory = w_data_cycle ? w_load_fmt : ((r_state == DONE) ? r_capture : 32'd0);
  assign memory_stall     = w_rd_req || (w_wr_req && !w_accept) || ((r_state == RDATA) && (r_count != 3'd1));
  assign address_error    = (r_state == IDLE) && (memory_read_memory || memory_write_memory)
                            && w_misaligned && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= 3'd0;
      r_capture <= 32'd0;
    end else begin
      case (r_state)
        IDLE, REQ: begin
          if (w_rd_req) begin
            if (w_accept) begin
              r_state <= RDATA;
              r_count <= LAT;
            end else begin
              r_state <= REQ;
            end
          end else if (w_wr_req) begin
            // An accepted write parks in DONE while the pipeline is held so it is not reissued.
            if (w_accept) r_state <= external_stall ? DONE : IDLE;
            else          r_state <= REQ;
          end else begin
            r_state <= IDLE;
          end
        end
        RDATA: begin
          if (r_count == 3'd1) begin
            r_count <= 3'd0;
            if (external_stall) begin
              r_capture <= w_load_fmt;
              r_state   <= DONE;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_count <= r_count - 3'd1;
          end
        end
        DONE: begin
          if (!external_stall) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  a_no_read_and_write: assert property (@(posedge clk) disable iff (reset)
    !(memory_read_memory && memory_write_memory));
endmodule
